// File: rtl/taus_combined_gen.sv
// Combined Tausworthe generator: NCOMP shift-register components XOR-combined into one word,
// with a serial reseed port (degenerate-seed substitution) and a valid/ready output register.
module taus_combined_gen #(
  parameter int WIDTH = 32,
  parameter int NCOMP = 3,
  parameter logic [NCOMP*WIDTH-1:0] SEEDS  = {32'd128, 32'd128, 32'd128},
  parameter logic [NCOMP*WIDTH-1:0] CONSTS = {32'hFFFFFFF0, 32'hFFFFFFF8, 32'hFFFFFFFE},
  parameter logic [NCOMP*6-1:0] SHIFT_L1 = {6'd3, 6'd2, 6'd13},
  parameter logic [NCOMP*6-1:0] SHIFT_R  = {6'd11, 6'd25, 6'd19},
  parameter logic [NCOMP*6-1:0] SHIFT_L2 = {6'd17, 6'd4, 6'd12}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [WIDTH-1:0] seed_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             seed_err
);

  // Handshake: a word moves on any edge where valid && ready are both high. seed_ready is
  // always high; out_valid stays up with out_data frozen until out_ready takes the word.

  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("taus_combined_gen: WIDTH must be 8..64");
  end
  if (NCOMP < 1 || NCOMP > 4) begin : g_bad_ncomp
    $error("taus_combined_gen: NCOMP must be 1..4");
  end
  for (genvar g = 0; g < NCOMP; g++) begin : g_chk
    if (int'(SHIFT_L1[g*6 +: 6]) >= WIDTH || int'(SHIFT_R[g*6 +: 6]) >= WIDTH ||
        int'(SHIFT_L2[g*6 +: 6]) >= WIDTH) begin : g_bad_shift
      $error("taus_combined_gen: shift amount must be below WIDTH");
    end
  end

  typedef enum logic {RUN, LOAD} state_t;

  localparam logic [2:0] LAST = 3'(NCOMP - 1);

  state_t           state;
  logic [2:0]       cnt;
  logic [2:0]       load_idx;
  logic [WIDTH-1:0] comp_s   [NCOMP];
  logic [WIDTH-1:0] next_s   [NCOMP];
  logic [WIDTH-1:0] seed_sub [NCOMP];
  logic [NCOMP-1:0] seed_deg;
  logic             deg_sel;
  logic [WIDTH-1:0] next_word;

  assign seed_ready = (state == RUN) || (state == LOAD);
  // The first word of a load always targets component 0, regardless of the stale counter.
  assign load_idx   = (state == RUN) ? 3'd0 : cnt;

  always_comb begin
    next_word = '0;
    deg_sel   = 1'b0;
    for (int k = 0; k < NCOMP; k++) begin
      next_s[k] = (((comp_s[k] << SHIFT_L1[k*6 +: 6]) ^ comp_s[k]) >> SHIFT_R[k*6 +: 6]) ^
                  ((comp_s[k] & CONSTS[k*WIDTH +: WIDTH]) << SHIFT_L2[k*6 +: 6]);
      seed_deg[k] = (seed_data & CONSTS[k*WIDTH +: WIDTH]) == '0;
      seed_sub[k] = seed_deg[k] ? SEEDS[k*WIDTH +: WIDTH] : seed_data;
      next_word   = next_word ^ next_s[k];
      if (load_idx == 3'(k)) deg_sel = seed_deg[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCOMP; k++) comp_s[k] <= SEEDS[k*WIDTH +: WIDTH];
      state     <= RUN;
      cnt       <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      seed_err  <= 1'b0;
    end else if (seed_valid) begin
      for (int k = 0; k < NCOMP; k++) begin
        if (load_idx == 3'(k)) comp_s[k] <= seed_sub[k];
      end
      // Accepting a seed drops any pending word; a same-edge out_ready still consumed it.
      out_valid <= 1'b0;
      seed_err  <= ((state == LOAD) && seed_err) || deg_sel;
      if (load_idx == LAST) begin
        state <= RUN;
        cnt   <= 3'd0;
      end else begin
        state <= LOAD;
        cnt   <= load_idx + 3'd1;
      end
    end else if (state == RUN && (!out_valid || out_ready)) begin
      for (int k = 0; k < NCOMP; k++) comp_s[k] <= next_s[k];
      out_data  <= next_word;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_taus_combined_gen.sv
// Directed bench for taus_combined_gen: a default three-component instance checked against a
// small taus88 reference model, plus a single-component instance with hand-computed vectors.
module tb_taus_combined_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_valid = 1'b0;
  logic        seed_ready;
  logic [31:0] seed_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        seed_err;

  logic        rst1 = 1'b1;
  logic        seed_valid1 = 1'b0;
  logic        seed_ready1;
  logic [31:0] seed_data1 = '0;
  logic        out_valid1;
  logic        out_ready1 = 1'b1;
  logic [31:0] out_data1;
  logic        seed_err1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m [3];
  logic [31:0] exp_w;

  always #5 clk = ~clk;

  taus_combined_gen dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed_data(seed_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .seed_err(seed_err)
  );

  taus_combined_gen #(
    .WIDTH(32), .NCOMP(1), .SEEDS(32'hFFFFFFFF), .CONSTS(32'hFFFFFFFF),
    .SHIFT_L1(6'd11), .SHIFT_R(6'd11), .SHIFT_L2(6'd11)
  ) dut1 (
    .clk(clk), .rst(rst1), .seed_valid(seed_valid1), .seed_ready(seed_ready1),
    .seed_data(seed_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .seed_err(seed_err1)
  );

  // Reference recurrences of the default taus88 parameter set, written out per component.
  function automatic logic [31:0] taus_f(input logic [31:0] s, input int k);
    logic [31:0] r;
    case (k)
      0:       r = (((s << 13) ^ s) >> 19) ^ ((s & 32'hFFFFFFFE) << 12);
      1:       r = (((s << 2) ^ s) >> 25) ^ ((s & 32'hFFFFFFF8) << 4);
      default: r = (((s << 3) ^ s) >> 11) ^ ((s & 32'hFFFFFFF0) << 17);
    endcase
    return r;
  endfunction

  task automatic model_seed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    m[0] = a; m[1] = b; m[2] = c;
  endtask

  task automatic model_step(output logic [31:0] w);
    w = '0;
    for (int k = 0; k < 3; k++) begin
      m[k] = taus_f(m[k], k);
      w = w ^ m[k];
    end
  endtask

  task automatic drive_seed(input logic [31:0] d);
    seed_valid = 1'b1;
    seed_data  = d;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; out_ready = 1'b1; seed_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (seed_err !== 1'b0) begin n_fail++; $display("FAIL reset_seed_err got %b want 0", seed_err); end
    n_checks++; if (seed_ready !== 1'b1) begin n_fail++; $display("FAIL reset_seed_ready got %b want 1", seed_ready); end
    rst = 1'b0;
    model_seed(32'd128, 32'd128, 32'd128);
    model_step(exp_w);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", out_valid); end
    n_checks++; if (out_data !== 32'h01080802) begin n_fail++; $display("FAIL first_word_hand got %h want 01080802", out_data); end
    n_checks++; if (out_data !== exp_w) begin n_fail++; $display("FAIL first_word_model got %h want %h", out_data, exp_w); end
  endtask

  task automatic test_throughput;
    for (int i = 0; i < 8; i++) begin
      model_step(exp_w);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_w) begin
        n_fail++; $display("FAIL throughput[%0d] got v=%b %h want v=1 %h", i, out_valid, out_data, exp_w);
      end
    end
  endtask

  task automatic test_single_comp;
    n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL single_reset_valid got %b want 0", out_valid1); end
    rst1 = 1'b0;
    @(negedge clk);
    n_checks++; if (out_data1 !== 32'hFFFFF800) begin n_fail++; $display("FAIL single_word1 got %h want FFFFF800", out_data1); end
    @(negedge clk);
    n_checks++; if (out_data1 !== 32'hFFC007FF) begin n_fail++; $display("FAIL single_word2 got %h want FFC007FF", out_data1); end
  endtask

  task automatic test_backpressure;
    logic [31:0] w1;
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_seed(32'd128, 32'd128, 32'd128);
    model_step(w1);
    @(negedge clk);
    n_checks++; if (out_data !== w1) begin n_fail++; $display("FAIL bp_first got %h want %h", out_data, w1); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== w1) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b %h want v=1 %h", i, out_valid, out_data, w1);
      end
    end
    out_ready = 1'b1;
    model_step(exp_w);
    @(negedge clk);
    n_checks++; if (out_data !== exp_w) begin n_fail++; $display("FAIL bp_second got %h want %h", out_data, exp_w); end
  endtask

  task automatic test_reseed;
    logic [31:0] sd [3];
    sd[0] = 32'h12345678; sd[1] = 32'h9ABCDEF0; sd[2] = 32'h0F0F0F0F;
    for (int i = 0; i < 3; i++) begin
      drive_seed(sd[i]);
      n_checks++;
      if (out_valid !== 1'b0 || seed_err !== 1'b0) begin
        n_fail++; $display("FAIL reseed_load[%0d] got v=%b err=%b want v=0 err=0", i, out_valid, seed_err);
      end
    end
    seed_valid = 1'b0;
    model_seed(sd[0], sd[1], sd[2]);
    model_step(exp_w);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_w) begin
      n_fail++; $display("FAIL reseed_first got v=%b %h want v=1 %h", out_valid, out_data, exp_w);
    end
    model_step(exp_w);
    @(negedge clk);
    n_checks++; if (out_data !== exp_w) begin n_fail++; $display("FAIL reseed_second got %h want %h", out_data, exp_w); end
  endtask

  task automatic test_degenerate;
    drive_seed(32'h00000001);
    n_checks++; if (seed_err !== 1'b1) begin n_fail++; $display("FAIL degen_err0 got %b want 1", seed_err); end
    drive_seed(32'h9ABCDEF0);
    drive_seed(32'h0F0F0F0F);
    n_checks++; if (seed_err !== 1'b1) begin n_fail++; $display("FAIL degen_err_sticky got %b want 1", seed_err); end
    seed_valid = 1'b0;
    model_seed(32'd128, 32'h9ABCDEF0, 32'h0F0F0F0F);
    model_step(exp_w);
    @(negedge clk);
    n_checks++; if (out_data !== exp_w) begin n_fail++; $display("FAIL degen_word got %h want %h", out_data, exp_w); end
    drive_seed(32'h12345678);
    n_checks++; if (seed_err !== 1'b0) begin n_fail++; $display("FAIL degen_clear got %b want 0", seed_err); end
    drive_seed(32'h00000003);
    n_checks++; if (seed_err !== 1'b1) begin n_fail++; $display("FAIL degen_comp1 got %b want 1", seed_err); end
    drive_seed(32'h0F0F0F0F);
    seed_valid = 1'b0;
    model_seed(32'h12345678, 32'd128, 32'h0F0F0F0F);
    model_step(exp_w);
    @(negedge clk);
    n_checks++; if (out_data !== exp_w) begin n_fail++; $display("FAIL degen_comp1_word got %h want %h", out_data, exp_w); end
    drive_seed(32'h12345678);
    drive_seed(32'h9ABCDEF0);
    drive_seed(32'h0F0F0F0F);
    seed_valid = 1'b0;
    n_checks++; if (seed_err !== 1'b0) begin n_fail++; $display("FAIL clean_load_err got %b want 0", seed_err); end
    model_seed(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F);
    model_step(exp_w);
    @(negedge clk);
  endtask

  task automatic test_collision_reset;
    logic [31:0] held;
    held = exp_w;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL coll_pre_valid got %b want 1", out_valid); end
    drive_seed(32'h00000001);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== held) begin
      n_fail++; $display("FAIL coll_no_step got v=%b %h want v=0 %h", out_valid, out_data, held);
    end
    drive_seed(32'h9ABCDEF0);
    seed_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_stall_valid got %b want 0", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (seed_err !== 1'b0) begin n_fail++; $display("FAIL midload_rst_err got %b want 0", seed_err); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h01080802) begin
      n_fail++; $display("FAIL midload_rst_word got v=%b %h want v=1 01080802", out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_single_comp();
    test_backpressure();
    test_reseed();
    test_degenerate();
    test_collision_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/taus_combined_gen.md
# taus_combined_gen

Parametrised combined Tausworthe pseudo-random generator: NCOMP independent shift-register components, each advancing by the recurrence s' = (((s << L1) ^ s) >> R) ^ ((s & C) << L2), with outputs XOR-combined into one WIDTH-bit word. Adds a serial reseed port with degenerate-seed substitution and a valid/ready output stage. It is the random source for the test-pattern and noise paths, and it replaces the single fixed 32-bit component.

## Interface
- WIDTH, 32: component and output word width, 8..64.
- NCOMP, 3: number of components, 1..4.
- SEEDS, {32'd128, 32'd128, 32'd128}: reset seeds, packed NCOMP*WIDTH, component 0 in LSBs.
- CONSTS, {32'hFFFFFFF0, 32'hFFFFFFF8, 32'hFFFFFFFE}: AND masks C, packed like SEEDS.
- SHIFT_L1, {6'd3, 6'd2, 6'd13}: left shift L1, packed NCOMP*6.
- SHIFT_R, {6'd11, 6'd25, 6'd19}: right shift R, packed NCOMP*6.
- SHIFT_L2, {6'd17, 6'd4, 6'd12}: left shift L2, packed NCOMP*6.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- seed_valid  in  1  seed word offered.
- seed_ready  out  1  seed word accepted when high with seed_valid.
- seed_data  in  WIDTH  seed word; words go to components 0..NCOMP-1 in order.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  WIDTH  combined random word.
- seed_err  out  1  sticky: a loaded seed was degenerate and was substituted.

## Operation
- Two states: RUN and LOAD. Reset state is RUN. seed_ready = 1 in both states.
- Step in RUN, when no seed is accepted and (!out_valid || out_ready): every component state s_k <= f_k(s_k), out_data <= XOR over k of f_k(s_k), out_valid <= 1. This is the only way component states advance.
- All shifts are logical and truncated to WIDTH bits. Shift fields are compared against WIDTH at elaboration, and any value >= WIDTH is an error.
- Seed accept in RUN: the word is written to component 0, the load counter is set to 1, and out_valid <= 0, which discards the pending word. If that same cycle also has out_valid && out_ready, the transfer counts as completed. No step occurs that cycle. The next state is LOAD, or RUN if NCOMP == 1.
- Seed accept in LOAD: the word is written to component cnt and cnt increments. After word NCOMP-1 the state returns to RUN. No steps and out_valid = 0 throughout LOAD.
- Degenerate seed: a word with (seed_data & C_k) == 0 is replaced by the SEEDS slice k and sets seed_err.
- seed_err clears on the first accepted word of each new load, then re-evaluates on every word of that load.
- out_data holds steady while out_valid && !out_ready.

## Timing
- Reset values:
  - states = SEEDS, FSM = RUN, cnt = 0.
  - out_valid = 0, out_data = 0, seed_err = 0.
  - seed_ready = 1 (combinational from the FSM, which is always 1).
- After reset release, out_valid rises at the first clk edge, carrying the step of SEEDS.
- With out_ready held high, the block produces one new word per cycle (100% throughput) and out_data changes every edge.
- Reload latency: a reseed takes NCOMP accept cycles. The first word from the new seeds has out_valid high 1 cycle after the last seed accept.
- Reset asserted mid-load abandons the load: SEEDS are restored and the FSM returns to RUN.
- seed_valid deasserted mid-load simply stalls LOAD. There is no timeout.

## Test plan
- Single-component vectors: NCOMP=1, WIDTH=32, CONSTS=32'hFFFFFFFF, all shifts 11, SEEDS=32'hFFFFFFFF, out_ready=1.
  - Required: out_data = 32'hFFFFF800, then 32'hFFC007FF, on consecutive cycles.
- Backpressure: default parameters, out_ready held low for 5 cycles after the first word.
  - Required: out_data and out_valid are constant.
  - When out_ready rises, the next word equals a free-running reference model's second word, so no step was lost or duplicated.
- Reseed: default parameters, load 3 words 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F back-to-back.
  - Required: out_valid = 0 during the load and seed_err = 0.
  - The first subsequent word equals the model's output for those seeds.
- Degenerate seed: load 32'h00000001 into component 0 (C0 = FFFFFFFE).
  - Required: seed_err = 1 and component 0 takes 32'd128.
  - The output matches the model with the substituted seed.
  - A following clean load clears seed_err.
- Collision and reset:
  - Seed accept in the same cycle as out_valid && out_ready: that word counts as consumed, the next cycle has out_valid = 0, and there is no step.
  - rst pulsed after 2 of 3 seed words: the first word after release equals the post-reset word from the first scenario's default-parameter model.
